// File: rtl/btn_pkg.sv
// Shared state type and clock-based timing helpers for the pushbutton
// conditioning path.
package btn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    REPEAT,
    RELEASE_WAIT
  } btn_state_t;

  localparam int CLK_HZ = 100_000_000;

  function automatic int ms_to_cycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_conditioner_sync_ff.sv
// Plain flop chain synchroniser for asynchronous inputs. It is shared by the
// buttons and the slide switches.
module sync_ff #(
  parameter int STAGES = 2,
  parameter int WIDTH  = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] chain_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      chain_q <= '0;
    end else begin
      chain_q <= {chain_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = chain_q[STAGES-1];

endmodule

// File: rtl/btn_conditioner.sv
// Turns one raw, bouncing pushbutton into a debounced level and one-clock
// press, release, auto-repeat and counter-step strobes.
module btn_conditioner
  import btn_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = ms_to_cycles(10),
  parameter int REPEAT_EN       = 1,
  parameter int REPEAT_DELAY    = ms_to_cycles(500),
  parameter int REPEAT_PERIOD   = ms_to_cycles(100)
) (
  input  logic CLK100MHZ,
  input  logic BTNU,
  input  logic btn_raw,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse,
  output logic repeat_pulse,
  output logic step_pulse
);

  localparam int CNT_MAX = max3(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_C    = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] DELAY_C  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(REPEAT_PERIOD);

  logic             s;
  btn_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             repeat_q, repeat_d;
  logic             step_q;

  sync_ff #(
    .STAGES(SYNC_STAGES),
    .WIDTH (1)
  ) u_sync (
    .clk_i(CLK100MHZ),
    .rst_i(BTNU),
    .d_i  (btn_raw),
    .q_o  (s)
  );

  assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

  // The edge that enters a state counts as its first clock. The one exception
  // is a bounce during release: it restarts the repeat delay from zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_inc;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (s) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == DEB_C) begin
          state_d = HELD;
          cnt_d   = CNT_ONE;
          level_d = 1'b1;
          press_d = 1'b1;
        end
      end
      HELD: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end else if ((REPEAT_EN != 0) && (cnt_q == DELAY_C)) begin
          state_d  = REPEAT;
          cnt_d    = CNT_ONE;
          repeat_d = 1'b1;
        end
      end
      REPEAT: begin
        if (!s) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end else if (cnt_q == PERIOD_C) begin
          cnt_d    = CNT_ONE;
          repeat_d = 1'b1;
        end
      end
      RELEASE_WAIT: begin
        if (s) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == DEB_C) begin
          state_d   = IDLE;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (BTNU) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      repeat_q  <= 1'b0;
      step_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      repeat_q  <= repeat_d;
      step_q    <= press_d | repeat_d;
    end
  end

  assign btn_level     = level_q;
  assign press_pulse   = press_q;
  assign release_pulse = release_q;
  assign repeat_pulse  = repeat_q;
  assign step_pulse    = step_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner: one instance with auto-repeat enabled
// and one with it disabled, both driven by the same button and reset.
module tb_btn_conditioner;
  import btn_pkg::*;

  logic clk;
  logic BTNU;
  logic btn_raw;
  logic levelA, pressA, releaseA, repeatA, stepA;
  logic levelB, pressB, releaseB, repeatB, stepB;

  int testsRun = 0;
  int failures = 0;
  int cyc = 0;
  int base = 0;
  int idx;
  bit monitorEn = 0;
  bit levelSeen;
  logic levelHist [0:63];
  logic prevPressA, prevReleaseA, prevRepeatA, prevStepA;
  logic prevPressB, prevReleaseB, prevRepeatB, prevStepB;

  int pressQA[$], releaseQA[$], repeatQA[$], stepQA[$];
  int pressQB[$], releaseQB[$], repeatQB[$], stepQB[$];

  btn_conditioner #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(1),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dut (
    .CLK100MHZ(clk), .BTNU(BTNU), .btn_raw(btn_raw),
    .btn_level(levelA), .press_pulse(pressA), .release_pulse(releaseA),
    .repeat_pulse(repeatA), .step_pulse(stepA)
  );

  btn_conditioner #(
    .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .REPEAT_EN(0),
    .REPEAT_DELAY(10), .REPEAT_PERIOD(3)
  ) dutNoRep (
    .CLK100MHZ(clk), .BTNU(BTNU), .btn_raw(btn_raw),
    .btn_level(levelB), .press_pulse(pressB), .release_pulse(releaseB),
    .repeat_pulse(repeatB), .step_pulse(stepB)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Event recorder plus the always-on exclusivity, pulse-width and step checks.
  always @(negedge clk) begin
    if (monitorEn) begin
      idx = cyc - base;
      if (pressA) pressQA.push_back(idx);
      if (releaseA) releaseQA.push_back(idx);
      if (repeatA) repeatQA.push_back(idx);
      if (stepA) stepQA.push_back(idx);
      if (pressB) pressQB.push_back(idx);
      if (releaseB) releaseQB.push_back(idx);
      if (repeatB) repeatQB.push_back(idx);
      if (stepB) stepQB.push_back(idx);
      if (levelA) levelSeen = 1;
      if (idx >= 0 && idx < 64) levelHist[idx] = levelA;
      testsRun++;
      if ((32'(pressA) + 32'(releaseA) + 32'(repeatA)) > 1 ||
          (32'(pressB) + 32'(releaseB) + 32'(repeatB)) > 1) begin
        failures++;
        $display("[TB] FAIL exclusivity cycle %0d: A p/r/rep=%b%b%b B=%b%b%b, required at most one high",
                 idx, pressA, releaseA, repeatA, pressB, releaseB, repeatB);
      end
      testsRun++;
      if ((pressA && prevPressA) || (releaseA && prevReleaseA) ||
          (repeatA && prevRepeatA) || (stepA && prevStepA) ||
          (pressB && prevPressB) || (releaseB && prevReleaseB) ||
          (repeatB && prevRepeatB) || (stepB && prevStepB)) begin
        failures++;
        $display("[TB] FAIL pulse_width cycle %0d: a strobe stayed high two cycles, required one", idx);
      end
      testsRun++;
      if (stepA !== (pressA | repeatA) || stepB !== (pressB | repeatB)) begin
        failures++;
        $display("[TB] FAIL step_is_press_or_repeat cycle %0d: A step=%b B step=%b, required A=%b B=%b",
                 idx, stepA, stepB, pressA | repeatA, pressB | repeatB);
      end
    end
    prevPressA = pressA; prevReleaseA = releaseA; prevRepeatA = repeatA; prevStepA = stepA;
    prevPressB = pressB; prevReleaseB = releaseB; prevRepeatB = repeatB; prevStepB = stepB;
  end

  function automatic bit sameList(input int a[$], input int b[$]);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] != b[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic v, input int n);
    btn_raw = v;
    repeat (n) tick();
  endtask

  // Resets both instances, clears the recorders and names the next edge 0.
  task automatic startWindow();
    monitorEn = 0;
    btn_raw = 1'b0;
    BTNU = 1'b1;
    tick();
    BTNU = 1'b0;
    tick();
    tick();
    pressQA.delete(); releaseQA.delete(); repeatQA.delete(); stepQA.delete();
    pressQB.delete(); releaseQB.delete(); repeatQB.delete(); stepQB.delete();
    levelSeen = 0;
    for (int i = 0; i < 64; i++) levelHist[i] = 1'bx;
    base = cyc;
    monitorEn = 1;
  endtask

  task automatic test_reset();
    BTNU = 1'b1;
    btn_raw = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    testsRun++;
    if ({levelA, pressA, releaseA, repeatA, stepA} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs_A: got %b, required 00000", {levelA, pressA, releaseA, repeatA, stepA});
    end
    testsRun++;
    if ({levelB, pressB, releaseB, repeatB, stepB} !== 5'b0) begin
      failures++;
      $display("[TB] FAIL reset_outputs_B: got %b, required 00000", {levelB, pressB, releaseB, repeatB, stepB});
    end
    testsRun++;
    if (dut.state_q !== IDLE) begin
      failures++;
      $display("[TB] FAIL reset_state: got %0d, required IDLE", dut.state_q);
    end
    btn_raw = 1'b0;
    BTNU = 1'b0;
    repeat (4) tick();
  endtask

  task automatic test_clean_press();
    int exp7[$];
    int exp15[$];
    exp7 = '{7};
    exp15 = '{15};
    startWindow();
    hold(1'b1, 8);
    hold(1'b0, 14);
    testsRun++;
    if (!sameList(pressQA, exp7) || !sameList(stepQA, exp7)) begin
      failures++;
      $display("[TB] FAIL clean_press: press at %p step at %p, required press and step at %p", pressQA, stepQA, exp7);
    end
    testsRun++;
    if (levelHist[6] !== 1'b0 || levelHist[7] !== 1'b1 || levelHist[14] !== 1'b1 || levelHist[15] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL clean_level: cycles 6/7/14/15 = %b%b%b%b, required 0110",
               levelHist[6], levelHist[7], levelHist[14], levelHist[15]);
    end
    testsRun++;
    if (!sameList(releaseQA, exp15) || repeatQA.size() != 0) begin
      failures++;
      $display("[TB] FAIL clean_release: release at %p repeats %0d, required release at %p and 0 repeats",
               releaseQA, repeatQA.size(), exp15);
    end
    testsRun++;
    if (!sameList(stepQB, exp7) || !sameList(releaseQB, exp15)) begin
      failures++;
      $display("[TB] FAIL clean_press_norep: step at %p release at %p, required %p and %p", stepQB, releaseQB, exp7, exp15);
    end
  endtask

  task automatic test_bounce_reject();
    startWindow();
    hold(1'b1, 3);
    hold(1'b0, 2);
    hold(1'b1, 3);
    hold(1'b0, 15);
    testsRun++;
    if ((pressQA.size() + releaseQA.size() + repeatQA.size() + stepQA.size() +
         pressQB.size() + releaseQB.size() + stepQB.size()) != 0) begin
      failures++;
      $display("[TB] FAIL bounce_reject: A press/rel/rep/step=%0d/%0d/%0d/%0d B step=%0d, required all 0",
               pressQA.size(), releaseQA.size(), repeatQA.size(), stepQA.size(), stepQB.size());
    end
    testsRun++;
    if (levelSeen) begin
      failures++;
      $display("[TB] FAIL bounce_level: btn_level went 1, required to stay 0");
    end
  endtask

  task automatic test_auto_repeat();
    int expStep[$];
    int expRep[$];
    int expOne[$];
    int expRel[$];
    expStep = '{7, 17, 20, 23, 26, 29};
    expRep = '{17, 20, 23, 26, 29};
    expOne = '{7};
    expRel = '{36};
    startWindow();
    hold(1'b1, 29);
    hold(1'b0, 12);
    testsRun++;
    if (!sameList(stepQA, expStep)) begin
      failures++;
      $display("[TB] FAIL repeat_steps: step at %p, required %p", stepQA, expStep);
    end
    testsRun++;
    if (!sameList(repeatQA, expRep) || !sameList(pressQA, expOne)) begin
      failures++;
      $display("[TB] FAIL repeat_pulses: repeat at %p press at %p, required %p and %p", repeatQA, pressQA, expRep, expOne);
    end
    testsRun++;
    if (!sameList(stepQB, expOne) || repeatQB.size() != 0) begin
      failures++;
      $display("[TB] FAIL repeat_disabled: step at %p repeats %0d, required step at %p and 0 repeats",
               stepQB, repeatQB.size(), expOne);
    end
    testsRun++;
    if (!sameList(releaseQA, expRel) || !sameList(releaseQB, expRel)) begin
      failures++;
      $display("[TB] FAIL repeat_release: A at %p B at %p, required %p", releaseQA, releaseQB, expRel);
    end
  endtask

  task automatic test_release_bounce();
    int expOne[$];
    int expRel[$];
    expOne = '{7};
    expRel = '{22};
    startWindow();
    hold(1'b1, 12);
    hold(1'b0, 2);
    hold(1'b1, 1);
    hold(1'b0, 12);
    testsRun++;
    if (!sameList(releaseQA, expRel) || !sameList(releaseQB, expRel)) begin
      failures++;
      $display("[TB] FAIL release_bounce: A release at %p B at %p, required %p", releaseQA, releaseQB, expRel);
    end
    testsRun++;
    if (!sameList(stepQA, expOne) || !sameList(pressQA, expOne) || repeatQA.size() != 0) begin
      failures++;
      $display("[TB] FAIL release_bounce_strobes: press %p step %p repeats %0d, required %p %p 0",
               pressQA, stepQA, repeatQA.size(), expOne, expOne);
    end
    testsRun++;
    if (levelHist[16] !== 1'b1 || levelHist[21] !== 1'b1 || levelHist[22] !== 1'b0) begin
      failures++;
      $display("[TB] FAIL release_bounce_level: cycles 16/21/22 = %b%b%b, required 110",
               levelHist[16], levelHist[21], levelHist[22]);
    end
  endtask

  task automatic test_reset_mid_op();
    int expPress[$];
    int expStepA[$];
    int expRel[$];
    expPress = '{7, 26};
    expStepA = '{7, 17, 26};
    expRel = '{37};
    startWindow();
    btn_raw = 1'b1;
    repeat (18) tick();
    testsRun++;
    if (dut.state_q !== REPEAT || dut.cnt_q != 2) begin
      failures++;
      $display("[TB] FAIL mid_op_precondition: state %0d cnt %0d, required REPEAT and 2", dut.state_q, dut.cnt_q);
    end
    BTNU = 1'b1;
    tick();
    BTNU = 1'b0;
    @(negedge clk);
    testsRun++;
    if ({levelA, pressA, releaseA, repeatA, stepA, levelB, stepB} !== 7'b0 || dut.state_q !== IDLE) begin
      failures++;
      $display("[TB] FAIL mid_op_reset: outputs %b state %0d, required 0000000 and IDLE",
               {levelA, pressA, releaseA, repeatA, stepA, levelB, stepB}, dut.state_q);
    end
    repeat (11) tick();
    hold(1'b0, 12);
    testsRun++;
    if (!sameList(pressQA, expPress) || !sameList(stepQA, expStepA) || !sameList(pressQB, expPress)) begin
      failures++;
      $display("[TB] FAIL mid_op_repress: A press %p step %p B press %p, required %p %p %p",
               pressQA, stepQA, pressQB, expPress, expStepA, expPress);
    end
    testsRun++;
    if (!sameList(releaseQA, expRel) || !sameList(releaseQB, expRel)) begin
      failures++;
      $display("[TB] FAIL mid_op_release: A at %p B at %p, required only %p", releaseQA, releaseQB, expRel);
    end
  endtask

  task automatic test_glitch_soak();
    startWindow();
    while ((cyc - base) < 10000) begin
      hold(1'b1, int'($urandom_range(1, 3)));
      hold(1'b0, int'($urandom_range(1, 4)));
    end
    hold(1'b0, 10);
    testsRun++;
    if ((pressQA.size() + releaseQA.size() + repeatQA.size() + stepQA.size() +
         pressQB.size() + releaseQB.size() + stepQB.size()) != 0 || levelSeen) begin
      failures++;
      $display("[TB] FAIL glitch_soak: A press/rel/rep/step=%0d/%0d/%0d/%0d level_seen=%0d, required all 0",
               pressQA.size(), releaseQA.size(), repeatQA.size(), stepQA.size(), levelSeen);
    end
  endtask

  initial begin
    BTNU = 1'b1;
    btn_raw = 1'b0;
    test_reset();
    test_clean_press();
    test_bounce_reject();
    test_auto_repeat();
    test_release_bounce();
    test_reset_mid_op();
    test_glitch_soak();
    monitorEn = 0;
    $display("[TB] %0d tests run, %0d failed", testsRun, failures);
    $finish;
  end

endmodule
